// File: rtl/bless_pkg.sv
// bless_pkg: flit header layout, tag type and size-mask helper for the ejection reassembly buffer.
// Flit layout LSB-first: 32-bit header in [31:0], bits [34:32] reserved, payload from bit 35 upward.
package bless_pkg;
  localparam int VLD_LSB     = 0;
  localparam int DST_LSB     = 1;
  localparam int DST_W       = 6;
  localparam int SEQ_LSB     = 7;
  localparam int SEQ_W       = 3;
  localparam int SIZE_LSB    = 10;
  localparam int SIZE_W      = 3;
  localparam int MSHR_LSB    = 13;
  localparam int MSHR_W      = 5;
  localparam int REQ_LSB     = 18;
  localparam int REQ_W       = 6;
  localparam int TS_LSB      = 24;
  localparam int TS_W        = 8;
  localparam int PAYLOAD_LSB = 35;
  localparam int TAG_W       = REQ_W + MSHR_W;
  typedef logic [TAG_W-1:0] tag_t;
  typedef enum logic {IDLE, DRAIN} state_t;
  function automatic logic [7:0] size_mask(input logic [SIZE_W-1:0] size);
    return 8'((9'd1 << size) - 9'd1);
  endfunction
endpackage

// File: rtl/bless_eject_reassembly_if.sv
// bless_eject_reassembly_if: router-side flit input and core-side valid/ready packet stream.
interface bless_eject_reassembly_if import bless_pkg::*; #(
  parameter int PAYLOAD_W  = 256,
  parameter int DATA_WIDTH = PAYLOAD_W + 35
) ();
  logic [DATA_WIDTH-1:0] flit_in;
  logic                  in_ready;
  logic                  out_valid;
  logic                  out_ready;
  logic [PAYLOAD_W-1:0]  out_data;
  tag_t                  out_tag;
  logic [SEQ_W-1:0]      out_seq;
  logic                  out_sop;
  logic                  out_eop;
  modport master (output flit_in, out_ready,
                  input  in_ready, out_valid, out_data, out_tag, out_seq, out_sop, out_eop);
  modport slave  (input  flit_in, out_ready,
                  output in_ready, out_valid, out_data, out_tag, out_seq, out_sop, out_eop);
endinterface

// File: rtl/bless_idx_fifo.sv
// bless_idx_fifo: completion-order FIFO of entry indices, depth NUM_ENTRIES (power of two).
module bless_idx_fifo #(
  parameter int NUM_ENTRIES = 4,
  localparam int IW = $clog2(NUM_ENTRIES)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [IW-1:0] push_data,
  input  logic          pop,
  output logic [IW-1:0] head,
  output logic          empty
);
  logic [IW-1:0] mem [NUM_ENTRIES];
  logic [IW:0]   wp, rp;
  assign head  = mem[rp[IW-1:0]];
  assign empty = wp == rp;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      wp <= wp + (IW+1)'(push);
      rp <= rp + (IW+1)'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem[wp[IW-1:0]] <= push_data;
endmodule

// File: rtl/bless_eject_reassembly.sv
// bless_eject_reassembly: collects out-of-order flits per tag and streams complete packets in seq order.
module bless_eject_reassembly import bless_pkg::*; #(
  parameter int PAYLOAD_W   = 256,
  parameter int DATA_WIDTH  = PAYLOAD_W + 35,
  parameter int NUM_ENTRIES = 4,
  parameter int MAX_FLITS   = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  bless_eject_reassembly_if.slave      bus,
  output logic                         dup_err,
  output logic                         size_err,
  output logic [$clog2(NUM_ENTRIES):0] occupancy
);
  localparam int IW = $clog2(NUM_ENTRIES);
  localparam int OW = IW + 1;
  logic [NUM_ENTRIES-1:0] valid, cmpl;
  tag_t                   tag    [NUM_ENTRIES];
  logic [SIZE_W-1:0]      size   [NUM_ENTRIES];
  logic [MAX_FLITS-1:0]   bitmap [NUM_ENTRIES];
  logic [PAYLOAD_W-1:0]   payload [NUM_ENTRIES][MAX_FLITS];
  logic                   vld, acc, bad, hit, dup, wr, alloc, done, fire, free_e, pop, empty;
  logic [SEQ_W-1:0]       seq, nxt;
  logic [SIZE_W-1:0]      psize;
  tag_t                   ftag;
  logic [PAYLOAD_W-1:0]   fdata;
  logic [IW-1:0]          hit_idx, free_idx, wr_idx, idx, head;
  logic [MAX_FLITS-1:0]   bm_new;
  logic [OW-1:0]          occ_next;
  logic                   unused_bits;
  state_t                 state;
  assign vld         = bus.flit_in[VLD_LSB];
  assign seq         = bus.flit_in[SEQ_LSB +: SEQ_W];
  assign psize       = bus.flit_in[SIZE_LSB +: SIZE_W];
  assign ftag        = bus.flit_in[MSHR_LSB +: TAG_W];
  assign fdata       = bus.flit_in[DATA_WIDTH-1 -: PAYLOAD_W];
  assign unused_bits = ^{bus.flit_in[DST_LSB +: DST_W], bus.flit_in[PAYLOAD_LSB-1:TS_LSB]};
  // Only entries still collecting flits can match; complete/draining ones force a fresh allocation.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    free_idx = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (!valid[i]) free_idx = IW'(i);
      if (valid[i] && !cmpl[i] && tag[i] == ftag) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
    end
  end
  assign acc      = vld && bus.in_ready;
  assign bad      = psize == '0 || int'(psize) > MAX_FLITS || seq >= psize;
  assign dup      = hit && bitmap[hit_idx][seq];
  assign wr       = acc && !bad && !dup;
  assign alloc    = wr && !hit;
  assign wr_idx   = hit ? hit_idx : free_idx;
  assign bm_new   = (hit ? bitmap[hit_idx] : '0) | (MAX_FLITS'(1) << seq);
  assign done     = wr && bm_new == MAX_FLITS'(size_mask(hit ? size[hit_idx] : psize));
  assign fire     = state == DRAIN && bus.out_ready;
  assign free_e   = fire && bus.out_eop;
  assign pop      = state == IDLE && !empty;
  assign nxt      = bus.out_seq + SEQ_W'(1);
  assign occ_next = occupancy + OW'(alloc) - OW'(free_e);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      valid        <= '0;
      cmpl         <= '0;
      occupancy    <= '0;
      bus.in_ready <= 1'b1;
      dup_err      <= 1'b0;
      size_err     <= 1'b0;
    end else begin
      if (free_e) begin
        valid[idx] <= 1'b0;
        cmpl[idx]  <= 1'b0;
      end
      if (wr) begin
        valid[wr_idx] <= 1'b1;
        cmpl[wr_idx]  <= done;
      end
      occupancy    <= occ_next;
      bus.in_ready <= occ_next != OW'(NUM_ENTRIES);
      dup_err      <= acc && !bad && dup;
      size_err     <= acc && bad;
    end
  always_ff @(posedge clk)
    if (wr) begin
      bitmap[wr_idx]       <= bm_new;
      payload[wr_idx][seq] <= fdata;
      if (!hit) begin
        tag[wr_idx]  <= ftag;
        size[wr_idx] <= psize;
      end
    end
  bless_idx_fifo #(.NUM_ENTRIES(NUM_ENTRIES)) u_fifo (
    .clk(clk), .reset(reset), .push(done), .push_data(wr_idx), .pop(pop), .head(head), .empty(empty)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state         <= IDLE;
      idx           <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_tag   <= '0;
      bus.out_seq   <= '0;
      bus.out_sop   <= 1'b0;
      bus.out_eop   <= 1'b0;
    end else if (pop) begin
      state         <= DRAIN;
      idx           <= head;
      bus.out_valid <= 1'b1;
      bus.out_data  <= payload[head][0];
      bus.out_tag   <= tag[head];
      bus.out_seq   <= '0;
      bus.out_sop   <= 1'b1;
      bus.out_eop   <= size[head] == SIZE_W'(1);
    end else if (fire) begin
      state         <= bus.out_eop ? IDLE : DRAIN;
      bus.out_valid <= !bus.out_eop;
      bus.out_data  <= bus.out_eop ? bus.out_data : payload[idx][nxt];
      bus.out_seq   <= bus.out_eop ? bus.out_seq : nxt;
      bus.out_sop   <= 1'b0;
      bus.out_eop   <= !bus.out_eop && nxt == size[idx] - SIZE_W'(1);
    end
endmodule

// File: doc/bless_eject_reassembly.md
Name: bless_eject_reassembly

Overview:
- Parametrised ejection-side reassembly buffer attached to the local output port (data_out_l) of the bufferless deflection router.
- Deflection routing delivers the flits of one multi-flit packet out of order and interleaved with other packets.
- This block collects flits per {requesterID, mshrID}, detects packet completion and streams each complete packet to the local core in flitSeqNum order over a valid/ready interface.
- It replaces the direct single-flit ejection path.

Parameters:
- PAYLOAD_W, 256, payload bits per flit.
- DATA_WIDTH, PAYLOAD_W+35, full flit width. Header fields MSB→LSB: timestamp 8, requesterID 6, mshrID 5, pktSize 3, flitSeqNum 3, dst 6, vld 1.
- NUM_ENTRIES, 4, concurrent packets under reassembly; power of two, ≥2.
- MAX_FLITS, 8, maximum flits per packet; must be ≤ 2^3.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- flit_in  in  DATA_WIDTH  ejected flit from the router local output; the vld bit qualifies it.
- in_ready  out  1  registered; high when ≥1 entry is free. The router ejects only while in_ready=1 and deflects otherwise.
- out_valid  out  1  reassembled flit available.
- out_ready  in  1  core accepts the flit.
- out_data  out  PAYLOAD_W  payload of the current flit.
- out_tag  out  11  {requesterID, mshrID} of the current packet.
- out_seq  out  3  flitSeqNum of the current flit.
- out_sop  out  1  first flit of the packet.
- out_eop  out  1  last flit of the packet.
- dup_err  out  1  one-cycle pulse: duplicate flitSeqNum received.
- size_err  out  1  one-cycle pulse: pktSize=0, pktSize>MAX_FLITS, or flitSeqNum≥pktSize.
- occupancy  out  $clog2(NUM_ENTRIES)+1  number of allocated entries.

Behaviour:
- Reset values: in_ready=1, out_valid=0, out_sop=0, out_eop=0, dup_err=0, size_err=0, occupancy=0, out_data/out_tag/out_seq=0. All entries invalid, FSM in IDLE, completion FIFO empty.
- Reset asserted mid-operation discards all partial and draining packets with no error pulse.
- Accept condition: vld=1 and in_ready=1 at the clock edge. A flit with vld=1 while in_ready=0 is a protocol violation and is ignored.
- Entry state: valid, tag, size, received bitmap[MAX_FLITS], payload array[MAX_FLITS], complete flag.
- Hit (a valid, non-complete entry whose tag matches): write the payload to slot[seq] and set bitmap[seq].
- Hit with bitmap[seq] already set: payload is not written; dup_err pulses the next cycle.
- Miss: allocate the lowest-index free entry; record tag and size; write the payload slot; set the bit.
- A flit whose tag matches an entry already complete or draining is treated as a new packet.
- Size violation: the flit is dropped, nothing is allocated, and size_err pulses the next cycle.
- Completion: when the bitmap equals (1<<size)-1 after the update, set the complete flag and push the entry index into the completion FIFO at the same edge.
- Packets are delivered in completion order, not arrival order.
- A single-flit packet (size=1) completes on allocation.
- Output FSM:
  - IDLE: if the FIFO is non-empty, pop the index, set cnt=0, go to DRAIN.
  - DRAIN: out_valid=1; out_data=payload[idx][cnt]; out_seq=cnt; out_sop=(cnt==0); out_eop=(cnt==size-1).
  - On out_valid&&out_ready: if eop, clear the entry's valid and go to IDLE; else cnt++.
  - Outputs are held stable while out_ready=0.
- Latency: the final flit is accepted at edge E0 and out_valid rises after edge E1. Throughput is one flit per cycle within a packet plus one bubble cycle between packets.
- in_ready is registered from next-state free count (NUM_ENTRIES - occupancy_next ≥ 1).
- Allocation and free in the same cycle: the freed entry is usable from the next cycle; occupancy reflects the net change.
- The completion FIFO has NUM_ENTRIES depth and cannot overflow.

Decomposition:
- Package bless_pkg holds:
  - Header field LSB offsets and widths.
  - A tag type of 11 bits.
  - A helper function for the size mask.
- Sub-module bless_idx_fifo: synchronous FIFO of $clog2(NUM_ENTRIES)-bit indices, depth NUM_ENTRIES, same clk/reset.

Test Plan:
- Single-flit packet: tag {5,9}, size=1, seq=0, payload 'hA, out_ready=1 → out_valid 2 cycles later with sop=eop=1, out_data='hA; occupancy goes 1→0.
- Out-of-order 3-flit packet: seq order 2,0,1 for tag {1,5}, payloads 'hC,'hA,'hB → outputs 'hA,'hB,'hC on consecutive cycles; sop on 'hA, eop on 'hC.
- Interleaved packets A {2,6} size 2 and B {3,7} size 2: B completes first → B drained before A; both tags correct.
- Fill and back-pressure: 4 incomplete packets → in_ready=0, occupancy=4. Complete one and drain it with out_ready held low 3 cycles → outputs stable; after eop, in_ready returns to 1.
- Errors: duplicate seq=1 on tag {4,8} → dup_err one cycle, original payload kept. pktSize=0 → size_err one cycle, occupancy unchanged.
- Reset mid-drain: assert reset during DRAIN of a 4-flit packet → out_valid=0 immediately, occupancy=0, in_ready=1.
